sfx_tone_sequencer: RTL and testbench

Parametrised one-shot sound-effect generator for the game audio path: a rising edge on `trigger` plays a fixed sequence of square-wave notes, rests and gaps on a single 1-bit output that drives the speaker mixer. Generalises the per-event collision sounds into a single block with configurable note count, pitch table, note length, inter-note gap, repeat count and retrigger policy. One instance is used per sound event (water, car hit, hop, level clear).

---
 rtl/sfx_pkg.sv | 21 ++
 rtl/sfx_square_osc.sv | 44 ++++
 rtl/sfx_tone_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_sfx_tone_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg
// Shared definitions for the sound-effect sequencer family.
//   sfx_state_t : sequencer state (IDLE, TONE, GAP)
//   CLK_HZ      : system clock frequency used to build pitch tables
//   half_period : converts a tone frequency in Hz into a half-period in
//                 clock cycles, for filling HALF_PERIODS tables
package sfx_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } sfx_state_t;

    function automatic int unsigned half_period(input int unsigned hz);
        return CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/sfx_square_osc.sv
// sfx_square_osc
// Square-wave oscillator with a registered output. The wave is high for
// `half` cycles, then low for `half` cycles. A restart reloads the phase and
// begins with the high phase (or stays low when half is 0, which is a rest).
// Ports:
//   clk     in  1       system clock
//   reset   in  1       synchronous, active-high reset
//   restart in  1       start a fresh note using `half` on this edge
//   half    in  HALF_W  half-period in cycles; 0 forces the output low
//   wave    out 1       registered square wave
module sfx_square_osc
    import sfx_pkg::*;
#(
    parameter int unsigned HALF_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            wave  <= 1'b0;
        end else if (restart) begin
            // Every note starts on its high phase.
            phase <= '0;
            wave  <= (half != '0);
        end else if (half == '0) begin
            phase <= '0;
            wave  <= 1'b0;
        end else if (phase == half - HALF_W'(1)) begin
            phase <= '0;
            wave  <= ~wave;
        end else begin
            phase <= phase + HALF_W'(1);
        end
    end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// sfx_tone_sequencer
// One-shot sound-effect generator: a rising edge on `trigger` plays a fixed
// table of square-wave notes (entries of 0 are rests) with optional silent
// gaps between notes, repeated REPEATS times, on a single 1-bit output.
//
// Optional feature: define SFX_ABORT_EN to add the `abort` input, which
// stops playback on the next cycle without a `done` pulse.
//
// Ports:
//   clk      in  1      system clock (50 MHz)
//   reset    in  1      synchronous, active-high reset
//   trigger  in  1      level input; a rising edge starts playback
//   abort    in  1      (SFX_ABORT_EN only) stop playback, wins over trigger
//   tone_out out 1      square-wave audio output
//   busy     out 1      high while the sequence is playing
//   note_idx out IDX_W  index of the current note
//   done     out 1      one-cycle pulse when the final note ends
//
// Handshake: trigger is a level; only a 0->1 transition (trigger=1 while the
// sampled copy trig_q=0) starts playback. busy/done are registered and valid
// every cycle; done is a single-cycle pulse coincident with busy falling.
module sfx_tone_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned                   NUM_NOTES    = 2,
    parameter int unsigned                   HALF_W       = 17,
    parameter int unsigned                   DUR_W        = 24,
    parameter logic [NUM_NOTES*HALF_W-1:0]   HALF_PERIODS = {17'd45278, 17'd40337},
    parameter int unsigned                   NOTE_CYCLES  = 3125000,
    parameter int unsigned                   GAP_CYCLES   = 0,
    parameter int unsigned                   REPEATS      = 1,
    parameter int unsigned                   RETRIGGER    = 0,
    localparam int unsigned                  IDX_W        = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
`ifdef SFX_ABORT_EN
    input  logic             abort,
`endif
    output logic             tone_out,
    output logic             busy,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

    localparam int unsigned REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    sfx_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [REP_W-1:0]  rep;
    logic [DUR_W-1:0]  dur;
    logic              trig_q;

    logic              trig_edge;
    logic              abort_hit;
    logic              note_end;
    logic              gap_end;
    logic              last_note;
    logic              last_rep;
    logic [IDX_W-1:0]  next_idx;
    logic [REP_W-1:0]  next_rep;

    // Decisions for this edge, consumed by the FSM register block and the
    // oscillator so that tone_out is valid on the same cycle as the state.
    logic              start_note;
    logic [IDX_W-1:0]  start_idx;
    logic [REP_W-1:0]  start_rep;
    logic              go_gap;
    logic              go_idle;
    logic              fire_done;
    logic              keep_tone;

    logic              osc_restart;
    logic [HALF_W-1:0] osc_half;

    function automatic logic [HALF_W-1:0] note_half(input logic [IDX_W-1:0] i);
        logic [HALF_W-1:0] h;
        h = '0;
        for (int n = 0; n < int'(NUM_NOTES); n++) begin
            if (i == IDX_W'(n)) begin
                h = HALF_PERIODS[n*HALF_W +: HALF_W];
            end
        end
        return h;
    endfunction

    assign trig_edge = trigger && !trig_q;

`ifdef SFX_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign note_end  = (dur == DUR_W'(NOTE_CYCLES - 1));
    assign gap_end   = (GAP_CYCLES > 0) && (dur == DUR_W'(GAP_CYCLES - 1));
    assign last_note = (idx == IDX_W'(NUM_NOTES - 1));
    assign last_rep  = (rep == REP_W'(REPEATS - 1));
    // Wrapping at the end of the table advances the repeat count; the final
    // repeat never reaches this path, so rep cannot overflow.
    assign next_idx  = last_note ? '0 : idx + IDX_W'(1);
    assign next_rep  = last_note ? rep + REP_W'(1) : rep;

    always_comb begin
        start_note = 1'b0;
        start_idx  = idx;
        start_rep  = rep;
        go_gap     = 1'b0;
        go_idle    = 1'b0;
        fire_done  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    start_note = 1'b1;
                    start_idx  = '0;
                    start_rep  = '0;
                end
            end
            TONE: begin
                if (abort_hit) begin
                    go_idle = 1'b1;
                end else if ((RETRIGGER != 0) && trig_edge) begin
                    start_note = 1'b1;
                    start_idx  = '0;
                    start_rep  = '0;
                end else if (note_end) begin
                    if (last_note && last_rep) begin
                        go_idle   = 1'b1;
                        fire_done = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        go_gap = 1'b1;
                    end else begin
                        start_note = 1'b1;
                        start_idx  = next_idx;
                        start_rep  = next_rep;
                    end
                end
            end
            GAP: begin
                if (abort_hit) begin
                    go_idle = 1'b1;
                end else if ((RETRIGGER != 0) && trig_edge) begin
                    start_note = 1'b1;
                    start_idx  = '0;
                    start_rep  = '0;
                end else if (gap_end) begin
                    start_note = 1'b1;
                    start_idx  = next_idx;
                    start_rep  = next_rep;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    // Outside an ongoing note the oscillator is held in restart with a zero
    // half-period, which keeps tone_out low through GAP and IDLE.
    assign keep_tone   = (state == TONE) && !start_note && !go_gap && !go_idle;
    assign osc_restart = !keep_tone;

    always_comb begin
        osc_half = '0;
        if (start_note) begin
            osc_half = note_half(start_idx);
        end else if (keep_tone) begin
            osc_half = note_half(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            rep    <= '0;
            dur    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            trig_q <= 1'b1;
        end else begin
            trig_q <= trigger;
            done   <= fire_done;
            if (start_note) begin
                state <= TONE;
                idx   <= start_idx;
                rep   <= start_rep;
                dur   <= '0;
                busy  <= 1'b1;
            end else if (go_idle) begin
                state <= IDLE;
                idx   <= '0;
                rep   <= '0;
                dur   <= '0;
                busy  <= 1'b0;
            end else if (go_gap) begin
                state <= GAP;
                dur   <= '0;
            end else if (state != IDLE) begin
                dur <= dur + DUR_W'(1);
            end
        end
    end

    assign note_idx = idx;

    sfx_square_osc #(
        .HALF_W (HALF_W)
    ) u_osc (
        .clk     (clk),
        .reset   (reset),
        .restart (osc_restart),
        .half    (osc_half),
        .wave    (tone_out)
    );

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// tb_sfx_tone_sequencer
// Three sequencer instances sharing clock and reset:
//   dut_a : REPEATS=1, RETRIGGER=0 (table-driven single play)
//   dut_b : REPEATS=2
//   dut_c : RETRIGGER=1 (also used for abort when SFX_ABORT_EN is defined)
// Cycle t counts the edge that sampled the starting trigger edge as t=0;
// outputs are sampled 1 ns after each rising edge.
module tb_sfx_tone_sequencer;

    localparam logic [50:0] TABLE = {17'd2, 17'd0, 17'd3};

    logic clk = 1'b0;
    logic reset;
    logic trig_a, trig_b, trig_c;
    logic abort_off;
    logic abort_c;
    logic tone_a, busy_a, done_a;
    logic tone_b, busy_b, done_b;
    logic tone_c, busy_c, done_c;
    logic [1:0] idx_a, idx_b, idx_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sfx_tone_sequencer #(
        .NUM_NOTES(3), .HALF_PERIODS(TABLE), .NOTE_CYCLES(12),
        .GAP_CYCLES(2), .REPEATS(1), .RETRIGGER(0)
    ) dut_a (
        .clk(clk), .reset(reset), .trigger(trig_a),
`ifdef SFX_ABORT_EN
        .abort(abort_off),
`endif
        .tone_out(tone_a), .busy(busy_a), .note_idx(idx_a), .done(done_a)
    );

    sfx_tone_sequencer #(
        .NUM_NOTES(3), .HALF_PERIODS(TABLE), .NOTE_CYCLES(12),
        .GAP_CYCLES(2), .REPEATS(2), .RETRIGGER(0)
    ) dut_b (
        .clk(clk), .reset(reset), .trigger(trig_b),
`ifdef SFX_ABORT_EN
        .abort(abort_off),
`endif
        .tone_out(tone_b), .busy(busy_b), .note_idx(idx_b), .done(done_b)
    );

    sfx_tone_sequencer #(
        .NUM_NOTES(3), .HALF_PERIODS(TABLE), .NOTE_CYCLES(12),
        .GAP_CYCLES(2), .REPEATS(1), .RETRIGGER(1)
    ) dut_c (
        .clk(clk), .reset(reset), .trigger(trig_c),
`ifdef SFX_ABORT_EN
        .abort(abort_c),
`endif
        .tone_out(tone_c), .busy(busy_c), .note_idx(idx_c), .done(done_c)
    );

    typedef struct {
        logic       trig;
        logic       tone;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } vec_t;

    vec_t        vec[44];
    logic [0:39] pat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected tone for one full play (t = 0..39), zero outside it.
    function automatic logic play_tone(input int t);
        if (t >= 0 && t < 40) return pat[t];
        return 1'b0;
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;
        int early_done;

        // note0 half 3, gap, note1 rest, gap, note2 half 2
        pat = 40'b111000111000_00_000000000000_00_110011001100;

        for (int i = 0; i < 44; i++) begin
            vec[i].trig = (i < 5) || (i >= 20 && i < 23) || (i >= 40);
            vec[i].tone = play_tone(i);
            vec[i].busy = (i < 40);
            vec[i].done = (i == 40);
            vec[i].idx  = (i < 14) ? 2'd0 : (i < 28) ? 2'd1 : (i < 40) ? 2'd2 : 2'd0;
        end

        // Clock/reset: trigger held high through reset must not fire.
        reset     = 1'b1;
        trig_a    = 1'b1;
        trig_b    = 1'b0;
        trig_c    = 1'b0;
        abort_off = 1'b0;
        abort_c   = 1'b0;
        repeat (3) step();
        check("reset_tone_a", 32'(tone_a), 0);
        check("reset_busy_a", 32'(busy_a), 0);
        check("reset_done_a", 32'(done_a), 0);
        check("reset_idx_a",  32'(idx_a),  0);
        check("reset_busy_b", 32'(busy_b), 0);
        check("reset_busy_c", 32'(busy_c), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("held_trigger_no_play", 32'(busy_a), 0);
        end
        trig_a = 1'b0;
        step();

        // Table: single play, ignored edge at t=20, dropped edge on final cycle.
        for (int i = 0; i < 44; i++) begin
            trig_a = vec[i].trig;
            step();
            check($sformatf("vec%0d_tone", i), 32'(tone_a), 32'(vec[i].tone));
            check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vec[i].busy));
            check($sformatf("vec%0d_done", i), 32'(done_a), 32'(vec[i].done));
            check($sformatf("vec%0d_idx",  i), 32'(idx_a),  32'(vec[i].idx));
        end

        // REPEATS=2: second play begins at t=42 after a 2-cycle gap.
        busy_cnt = 0;
        done_cnt = 0;
        trig_b   = 1'b1;
        for (int t = 0; t < 120; t++) begin
            step();
            if (t == 3) trig_b = 1'b0;
            if (t < 82) check("rep2_tone", 32'(tone_b), 32'(play_tone((t < 42) ? t : t - 42)));
            if (busy_b) busy_cnt++;
            if (done_b) begin
                done_cnt++;
                check("rep2_done_time", t, 82);
            end
        end
        check("rep2_busy_cycles", busy_cnt, 82);
        check("rep2_done_count", done_cnt, 1);

        // RETRIGGER=1: edge sampled at t=21 restarts from note 0.
        early_done = 0;
        trig_c     = 1'b1;
        for (int t = 0; t < 70; t++) begin
            step();
            if (t == 2)  trig_c = 1'b0;
            if (t == 20) begin
                check("retrig_idx_before", 32'(idx_c), 1);
                trig_c = 1'b1;
            end
            if (t == 21) begin
                check("retrig_idx_after",  32'(idx_c),  0);
                check("retrig_tone_after", 32'(tone_c), 1);
                check("retrig_busy_after", 32'(busy_c), 1);
            end
            if (t == 60) check("retrig_busy_60", 32'(busy_c), 1);
            if (t == 61) begin
                check("retrig_busy_61", 32'(busy_c), 0);
                check("retrig_done_61", 32'(done_c), 1);
            end
            if (done_c && t != 61) early_done++;
        end
        check("retrig_no_early_done", early_done, 0);
        trig_c = 1'b0;

        // Reset asserted mid-play at t=15.
        trig_a = 1'b0;
        step();
        trig_a = 1'b1;
        for (int t = 0; t < 16; t++) begin
            step();
            if (t == 14) begin
                check("midreset_busy_before", 32'(busy_a), 1);
                check("midreset_idx_before",  32'(idx_a),  1);
                reset = 1'b1;
            end
        end
        check("midreset_tone", 32'(tone_a), 0);
        check("midreset_busy", 32'(busy_a), 0);
        check("midreset_done", 32'(done_a), 0);
        check("midreset_idx",  32'(idx_a),  0);
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step();
            check("postreset_busy", 32'(busy_a), 0);
            check("postreset_done", 32'(done_a), 0);
        end
        // Drop and re-raise: playback starts.
        trig_a = 1'b0;
        step();
        trig_a = 1'b1;
        step();
        check("reraise_busy", 32'(busy_a), 1);
        check("reraise_tone", 32'(tone_a), 1);

`ifdef SFX_ABORT_EN
        // Abort at t=5 together with a retrigger edge: abort wins.
        trig_c = 1'b1;
        step();
        check("abort_start_busy", 32'(busy_c), 1);
        trig_c = 1'b0;
        for (int t = 1; t < 5; t++) step();
        abort_c = 1'b1;
        trig_c  = 1'b1;
        step();
        check("abort_busy", 32'(busy_c), 0);
        check("abort_tone", 32'(tone_c), 0);
        check("abort_done", 32'(done_c), 0);
        check("abort_idx",  32'(idx_c),  0);
        abort_c = 1'b0;
        step();
        check("abort_edge_dropped", 32'(busy_c), 0);
        check("abort_no_done",      32'(done_c), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
